// File: rtl/fp32_mul_round_pack.sv
// Back end of the binary32 multiplier: normalizes the raw 48-bit significand product,
// rounds to nearest-even, saturates/flushes out-of-range exponents and packs the result.
module fp32_mul_round_pack #(
    parameter int D_WIDTH = 32,
    parameter int EXP_W   = 10,
    parameter int PROD_W  = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp_sum,
    input  logic [PROD_W-1:0]   in_mant_prod,
    input  logic [1:0]          in_special,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [D_WIDTH-1:0]  floating_multiplication_out,
    output logic                flag_overflow,
    output logic                flag_underflow,
    output logic                flag_inexact
);

    localparam logic [1:0] SP_ZERO = 2'b01;
    localparam logic [1:0] SP_INF  = 2'b10;
    localparam logic [1:0] SP_NAN  = 2'b11;

    // Handshake: a stage holds its contents until the stage after it can take them.
    // A transfer on either port happens on a rising edge where valid and ready are both 1;
    // out_valid and all result/flag outputs stay frozen while out_valid=1 and out_ready=0.
    logic s1_valid;
    logic s2_valid;
    logic s2_ready;
    logic s1_load;
    logic s2_load;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = s2_ready || !s1_valid;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid && s2_ready;
    assign out_valid = s2_valid;

    // Stage 1 registered fields
    logic               s1_sign;
    logic [1:0]         s1_special;
    logic signed [10:0] s1_exp;
    logic [22:0]        s1_mant;
    logic               s1_guard;
    logic               s1_sticky;

    // Normalization: the product lies in [1,4), so at most a single-bit right shift.
    logic               n_top;
    logic signed [10:0] n_exp;
    logic [22:0]        n_mant;
    logic               n_guard;
    logic               n_sticky;

    always_comb begin
        n_top = in_mant_prod[PROD_W-1];
        n_exp = 11'($signed(in_exp_sum)) + 11'(n_top);
        if (n_top) begin
            n_mant   = in_mant_prod[46:24];
            n_guard  = in_mant_prod[23];
            n_sticky = |in_mant_prod[22:0];
        end else begin
            n_mant   = in_mant_prod[45:23];
            n_guard  = in_mant_prod[22];
            n_sticky = |in_mant_prod[21:0];
        end
    end

    // Stage 2 combinational round and pack
    logic               round_up;
    logic [23:0]        rnd_mant;
    logic signed [11:0] rnd_exp;
    logic [31:0]        next_result;
    logic               next_ovf;
    logic               next_unf;
    logic               next_inx;

    always_comb begin
        round_up    = s1_guard & (s1_sticky | s1_mant[0]);
        rnd_mant    = {1'b0, s1_mant} + 24'(round_up);
        // A carry out of the fraction leaves it all zero and bumps the exponent.
        rnd_exp     = 12'(s1_exp) + 12'(rnd_mant[23]);
        next_result = 32'd0;
        next_ovf    = 1'b0;
        next_unf    = 1'b0;
        next_inx    = 1'b0;
        case (s1_special)
            SP_ZERO: next_result = {s1_sign, 31'd0};
            SP_INF:  next_result = {s1_sign, 8'hFF, 23'd0};
            SP_NAN:  next_result = 32'h7FC0_0000;
            default: begin
                if (rnd_exp >= 12'sd255) begin
                    next_result = {s1_sign, 8'hFF, 23'd0};
                    next_ovf    = 1'b1;
                    next_inx    = 1'b1;
                end else if (rnd_exp <= 12'sd0) begin
                    next_result = {s1_sign, 31'd0};
                    next_unf    = 1'b1;
                    next_inx    = 1'b1;
                end else begin
                    next_result = {s1_sign, rnd_exp[7:0], rnd_mant[22:0]};
                    next_inx    = s1_guard | s1_sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid                    <= 1'b0;
            s2_valid                    <= 1'b0;
            s1_sign                     <= 1'b0;
            s1_special                  <= 2'b00;
            s1_exp                      <= 11'sd0;
            s1_mant                     <= 23'd0;
            s1_guard                    <= 1'b0;
            s1_sticky                   <= 1'b0;
            floating_multiplication_out <= '0;
            flag_overflow               <= 1'b0;
            flag_underflow              <= 1'b0;
            flag_inexact                <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_sign    <= in_sign;
                s1_special <= in_special;
                s1_exp     <= n_exp;
                s1_mant    <= n_mant;
                s1_guard   <= n_guard;
                s1_sticky  <= n_sticky;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                floating_multiplication_out <= next_result;
                flag_overflow               <= next_ovf;
                flag_underflow              <= next_unf;
                flag_inexact                <= next_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Bench for fp32_mul_round_pack: directed corner cases, back-pressure, mid-stream reset
// and randomized products, scored against a value-level rounding model.
module tb_fp32_mul_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp_sum = '0;
    logic [47:0] in_mant_prod = '0;
    logic [1:0]  in_special = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] floating_multiplication_out;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int          checks = 0;
    int          failures = 0;
    logic [34:0] exp_q[$];
    logic        rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [34:0] held = '0;

    fp32_mul_round_pack dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .in_sign                     (in_sign),
        .in_exp_sum                  (in_exp_sum),
        .in_mant_prod                (in_mant_prod),
        .in_special                  (in_special),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .floating_multiplication_out (floating_multiplication_out),
        .flag_overflow               (flag_overflow),
        .flag_underflow              (flag_underflow),
        .flag_inexact                (flag_inexact)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: value = prod * 2^-46 * 2^(exp_sum-127); keep 24 significant bits,
    // round the discarded remainder to nearest-even, then range-check. Returns {ovf,unf,inx,word}.
    function automatic logic [34:0] model(input logic s, input int e, input logic [47:0] p,
                                          input logic [1:0] sp);
        longint unsigned pv, q, r, half;
        int sh, ex;
        logic inx;
        logic [7:0] eb;
        if (sp == 2'b11) return {3'b000, 32'h7FC00000};
        if (sp == 2'b10) return {3'b000, s, 8'hFF, 23'd0};
        if (sp == 2'b01) return {3'b000, s, 31'd0};
        pv   = 64'(p);
        sh   = (pv >= (64'd1 << 47)) ? 24 : 23;
        ex   = e + sh - 23;
        q    = pv >> sh;
        r    = pv - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (r != 0);
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'd0};
        if (ex <= 0) return {3'b011, s, 31'd0};
        eb = 8'(ex);
        return {2'b00, inx, s, eb, q[22:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    // driver tasks: called and return at posedge+1
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic s, input int e, input logic [47:0] p, input logic [1:0] sp);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid     = 1'b1;
        in_sign      = s;
        in_exp_sum   = 10'(e);
        in_mant_prod = p;
        in_special   = sp;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles required 1", n);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(model(s, e, p, sp));
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor: pops on every output transfer, checks hold while stalled
    always @(negedge clk) begin : monitor
        logic [34:0] got;
        logic [34:0] want;
        got = {flag_overflow, flag_underflow, flag_inexact, floating_multiplication_out};
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!out_valid || got !== held) begin
                    failures++;
                    $display("FAIL hold: got valid=%0b %h required valid=1 %h", out_valid, got, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got %h required no output", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL result: got {ovf,unf,inx,word}=%h required %h", got, want);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = got;
        end
    end

    initial begin
        logic [47:0] m1, m2;
        logic [1:0]  sp;
        int          wait_n;

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out", 64'(floating_multiplication_out), 64'd0);
        chk("reset_flags", 64'({flag_overflow, flag_underflow, flag_inexact}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed, back to back
        out_ready = 1'b1;
        send(1'b0, 128, 48'h780000000000, 2'b00);
        send(1'b0, 126, 48'h800000200000, 2'b00);
        send(1'b0, 127, 48'h7FFFFFC00000, 2'b00);
        send(1'b0, 254, 48'h7FFFFFC00000, 2'b00);
        send(1'b0, 254, 48'h400000000000, 2'b00);
        send(1'b0, 300, 48'h780000000000, 2'b00);
        send(1'b1, -5, 48'h780000000000, 2'b00);
        send(1'b0, 1, 48'h400000000000, 2'b00);
        send(1'b0, 0, 48'h400000000000, 2'b00);
        send(1'b0, 0, 48'h0, 2'b11);
        send(1'b1, 0, 48'h0, 2'b01);
        send(1'b1, 0, 48'h0, 2'b10);
        idle(4);

        // back-pressure
        out_ready = 1'b0;
        send(1'b0, 130, 48'h680000000000, 2'b00);
        send(1'b1, 128, 48'h780000000000, 2'b00);
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out", 64'(floating_multiplication_out), 64'h41500000);
        @(posedge clk);
        #1;
        fork
            send(1'b0, 126, 48'h800000200000, 2'b00);
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join
        idle(4);

        // reset with both stages full
        out_ready = 1'b0;
        send(1'b0, 130, 48'h680000000000, 2'b00);
        send(1'b0, 128, 48'h780000000000, 2'b00);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out", 64'(floating_multiplication_out), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(6);

        // randomized products with random gaps and random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 1));
            m1 = 48'($urandom_range(32'h00800000, 32'h00FFFFFF));
            m2 = 48'($urandom_range(32'h00800000, 32'h00FFFFFF));
            sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send(1'($urandom_range(0, 1)), $urandom_range(0, 320) - 20, m1 * m2, sp);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 100) begin
            idle(1);
            wait_n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_mul_round_pack.md
Name: fp32_mul_round_pack

Overview:
- Downstream stage of the single-precision floating-point multiplier datapath.
- Consumes the raw product from the mantissa-multiply stage: sign, biased exponent sum and 48-bit significand product. Produces the packed IEEE-754 binary32 result.
- Normalizes, rounds to nearest-even, handles overflow to infinity and underflow with flush-to-zero, and raises status flags.
- Two-stage pipeline with valid/ready handshake on both sides, so the multiplier array can be registered and back-pressured.

Parameters:
- D_WIDTH, 32, packed output width; fixed at 32 (binary32 only).
- EXP_W, 10, width of signed exponent-sum input.
- PROD_W, 48, width of significand product (24x24 with hidden bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  stage can accept a product this cycle.
- in_sign  input  1  product sign (s1 XOR s2).
- in_exp_sum  input  EXP_W  two's-complement e1+e2-127.
- in_mant_prod  input  PROD_W  {1.m1}*{1.m2}; value in [1,4).
- in_special  input  2  00 normal, 01 zero, 10 infinity, 11 NaN (classified upstream).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- floating_multiplication_out  output  D_WIDTH  packed result.
- flag_overflow  output  1  result overflowed to infinity.
- flag_underflow  output  1  result flushed to zero.
- flag_inexact  output  1  rounding discarded nonzero bits.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Both stage-valid bits cleared; out_valid=0.
  - floating_multiplication_out=0; all flags 0.
  - in_ready=1 the cycle after reset releases.
  - Reset mid-operation discards every in-flight product; nothing is emitted.
- Handshake:
  - A transfer occurs when valid & ready are both high at a clock edge.
  - in_ready = !s2_valid | out_ready | !s1_valid. Stage 1 advances when stage 2 is empty or draining.
  - Holds: out_valid and all output data/flags stay stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles, input accept edge to out_valid. Throughput is 1 per cycle with no back-pressure.
- Stage 1, normalize:
  - If prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=exp_sum+1.
  - Else: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=exp_sum.
  - Sign, special code and an 11-bit signed exp are registered with the normalized fields.
- Stage 2, round and pack:
  - round_up = guard & (sticky | mant[0]).
  - If the mantissa carries out of the round (all ones + 1): mant=0, exp+1.
  - inexact = guard | sticky.
  - exp >= 255: output {sign,8'hFF,23'b0}; overflow=1, inexact=1.
  - exp <= 0: output {sign,31'b0}; underflow=1, inexact=1. No subnormal outputs are produced.
  - Otherwise: {sign, exp[7:0], mant}.
- Specials bypass rounding; all flags 0:
  - zero -> {sign,31'b0}.
  - infinity -> {sign,8'hFF,23'b0}.
  - NaN -> 32'h7FC00000 (sign ignored).
- Boundaries:
  - Round carry producing exp=255 overflows to infinity.
  - Simultaneous input accept and output drain in the same cycle loses no data and duplicates none.
  - in_mant_prod with prod[47:46]=00 on a normal input is illegal; result is undefined but flags must not lock up the pipeline.

Test Plan:
- 1.5*2.5: sign 0, exp_sum 128, prod 48'h780000000000, special 00 -> 32'h40700000 two cycles later, flags 000.
- 10.0*0.1: sign 0, exp_sum 126, prod 48'h800000200000 -> 32'h3F800000, inexact=1, overflow=0, underflow=0.
- RNE tie with carry: exp_sum 127, prod 48'h7FFFFFC00000 -> 32'h40000000, inexact=1.
- Overflow/underflow/specials, one per cycle:
  - exp_sum 300, normal -> 32'h7F800000, overflow=1.
  - exp_sum -5, sign 1, normal -> 32'h80000000, underflow=1.
  - special 11 -> 32'h7FC00000.
  - special 01 with sign 1 -> 32'h80000000.
- Back-pressure: stream -6.5*-2.0 (exp_sum 130, prod 48'h680000000000) plus two more products while out_ready is held 0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - Output stays 32'h41500000 and stable while stalled.
  - All three results emerge in order once out_ready=1.
- Reset mid-stream: assert rst_n=0 for one cycle with both stages full -> out_valid=0 and output 0 next cycle; in_ready=1 after release; no stale result ever appears.
